count_window_ctrl: RTL and testbench

Sequencing controller for event counting over programmable windows in the counting-ADC front end. It arms a window counter, gates an N_BITS event counter for exactly `window_len` clock cycles, then freezes the result into a sample register. The sample is handed downstream through a valid/ready handshake. Single-shot and back-to-back (continuous, zero-gap) operation are both supported. It sits between the pulse-qualification logic and the decimation/readout path.

---
 rtl/count_window_pkg.sv | 20 ++
 rtl/count_window_if.sv | 28 ++
 rtl/count_window_ctrl_counter.sv | 45 ++++
 rtl/count_window_ctrl.sv | 107 ++++++++++
 tb/tb_count_window_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_window_pkg.sv
// count_window_pkg: shared types and defaults
// for the windowed event-count sequencer.
package count_window_pkg;

  localparam int N_BITS_DEF = 8;
  localparam int W_BITS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } cw_state_t;

  function automatic int unsigned sat_max(
    input int unsigned n
  );
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/count_window_if.sv
// count_window_if: sample handoff bundle
// between the sequencer and the readout path.
interface count_window_if
  import count_window_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) ();

  logic [N_BITS-1:0] sample;
  logic              sample_sat;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample,
    output sample_sat,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_sat,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/count_window_ctrl_counter.sv
// sat_event_counter: saturating event counter
// exposing its next value for same-cycle capture.
module sat_event_counter
  import count_window_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              inc,
  output logic [N_BITS-1:0] count_nxt,
  output logic              sat_nxt
);

  localparam logic [N_BITS-1:0] SAT_MAX =
    N_BITS'(sat_max(N_BITS));

  logic [N_BITS-1:0] count_q;
  logic              sat_q;
  logic              at_max;

  assign at_max = (count_q == SAT_MAX);

  // sat marks an event lost at full scale
  assign count_nxt = (inc && !at_max) ?
                     count_q + N_BITS'(1) :
                     count_q;
  assign sat_nxt   = sat_q | (inc & at_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (en) begin
      count_q <= count_nxt;
      sat_q   <= sat_nxt;
    end
  end

endmodule

// File: rtl/count_window_ctrl.sv
// count_window_ctrl: arms, gates and freezes
// event counts over programmable windows.
module count_window_ctrl
  import count_window_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int W_BITS = W_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [W_BITS-1:0] window_len,
  input  logic              event_in,
  output logic              busy,
  output logic              overrun,
  count_window_if.master    dn
);

  cw_state_t         state_q;
  cw_state_t         state_d;
  logic [W_BITS-1:0] len_q;
  logic [W_BITS-1:0] tmr_q;
  logic              accept;
  logic              abort;
  logic              last;
  logic              load;
  logic [N_BITS-1:0] cnt_nxt;
  logic              sat_nxt;

  assign accept = (state_q == IDLE) & start & ~stop;
  assign abort  = (state_q != IDLE) & stop;
  // len_q of 0 wraps to all-ones: a 2^W_BITS window
  assign last   = (state_q == COUNT) &&
                  (tmr_q == len_q - W_BITS'(1));
  assign load   = last & ~stop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ARM;
      ARM:     state_d = stop ? IDLE : COUNT;
      COUNT: begin
        if (stop || (last && !continuous))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      len_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (accept)
        len_q <= window_len;
      if (state_q == ARM || last)
        tmr_q <= '0;
      else if (state_q == COUNT)
        tmr_q <= tmr_q + W_BITS'(1);
    end
  end

  sat_event_counter #(
    .N_BITS (N_BITS)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       ((state_q == ARM) | last),
    .en        (state_q == COUNT),
    .inc       (event_in),
    .count_nxt (cnt_nxt),
    .sat_nxt   (sat_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dn.sample       <= '0;
      dn.sample_sat   <= 1'b0;
      dn.sample_valid <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      if (load) begin
        dn.sample       <= cnt_nxt;
        dn.sample_sat   <= sat_nxt;
        dn.sample_valid <= 1'b1;
      end else if (dn.sample_ready) begin
        dn.sample_valid <= 1'b0;
      end
      unique case (1'b1)
        accept | abort:
          overrun <= 1'b0;
        load & dn.sample_valid & ~dn.sample_ready:
          overrun <= 1'b1;
        default:
          overrun <= overrun;
      endcase
    end
  end

endmodule

// File: tb/tb_count_window_ctrl.sv
// tb_count_window_ctrl: directed checks of the
// window sequencer over three configurations.
module tb_count_window_ctrl;

  logic       clk;
  logic       reset;
  logic       start_a, start_b, start_c;
  logic       stop;
  logic       continuous;
  logic [9:0] wl;
  logic [3:0] wl4;
  logic       event_in;
  logic       ready;
  logic       busy_a, busy_b, busy_c;
  logic       ovr_a, ovr_b, ovr_c;

  int n_tests = 0;
  int n_fail  = 0;

  count_window_if #(.N_BITS(8)) ifa ();
  count_window_if #(.N_BITS(4)) ifb ();
  count_window_if #(.N_BITS(8)) ifc ();

  assign ifa.sample_ready = ready;
  assign ifb.sample_ready = ready;
  assign ifc.sample_ready = ready;
  assign wl4 = wl[3:0];

  count_window_ctrl #(.N_BITS(8), .W_BITS(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .stop(stop), .continuous(continuous),
    .window_len(wl), .event_in(event_in),
    .busy(busy_a), .overrun(ovr_a), .dn(ifa.master)
  );

  count_window_ctrl #(.N_BITS(4), .W_BITS(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .stop(stop), .continuous(continuous),
    .window_len(wl), .event_in(event_in),
    .busy(busy_b), .overrun(ovr_b), .dn(ifb.master)
  );

  count_window_ctrl #(.N_BITS(8), .W_BITS(4)) dut_c (
    .clk(clk), .reset(reset), .start(start_c),
    .stop(stop), .continuous(continuous),
    .window_len(wl4), .event_in(event_in),
    .busy(busy_c), .overrun(ovr_c), .dn(ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nv, ns, c;
    int s[3];
    int p[3];
    reset = 1'b0; start_a = 0; start_b = 0;
    start_c = 0; stop = 0; continuous = 0;
    wl = '0; event_in = 0; ready = 1;
    tick(); tick();
    chk("rst_sample", 32'(ifa.sample), 0);
    chk("rst_sat",    32'(ifa.sample_sat), 0);
    chk("rst_valid",  32'(ifa.sample_valid), 0);
    chk("rst_busy",   32'(busy_a), 0);
    chk("rst_ovr",    32'(ovr_a), 0);
    reset = 1'b1;
    tick();

    // single shot, L=10, all events
    wl = 10; event_in = 1; start_a = 1;
    tick();
    start_a = 0;
    nb = 0; nv = 0;
    for (int k = 1; k <= 11; k++) begin
      nb += int'(busy_a);
      nv += int'(ifa.sample_valid);
      tick();
    end
    chk("t1_busy_cycles", 32'(nb), 11);
    chk("t1_no_early_valid", 32'(nv), 0);
    chk("t1_busy_end", 32'(busy_a), 0);
    chk("t1_valid", 32'(ifa.sample_valid), 1);
    chk("t1_sample", 32'(ifa.sample), 10);
    chk("t1_sat", 32'(ifa.sample_sat), 0);
    tick();
    chk("t1_valid_pulse", 32'(ifa.sample_valid), 0);

    // saturation, N_BITS=4, L=20
    wl = 20; event_in = 1; start_b = 1;
    tick();
    start_b = 0;
    c = 1;
    while (!ifb.sample_valid && c < 60) begin
      tick(); c++;
    end
    chk("t2_time", 32'(c), 22);
    chk("t2_sample", 32'(ifb.sample), 15);
    chk("t2_sat", 32'(ifb.sample_sat), 1);
    tick();
    event_in = 0; start_b = 1;
    tick();
    start_b = 0;
    c = 1;
    while (!ifb.sample_valid && c < 60) begin
      tick(); c++;
    end
    chk("t2b_valid", 32'(ifb.sample_valid), 1);
    chk("t2b_sample", 32'(ifb.sample), 0);
    chk("t2b_sat", 32'(ifb.sample_sat), 0);
    tick();

    // continuous L=5, alternating events
    wl = 5; continuous = 1; event_in = 0;
    start_a = 1;
    tick();
    start_a = 0;
    tick();
    nb = 0; ns = 0;
    for (int k = 0; k < 17; k++) begin
      event_in = (k % 2 == 0);
      tick();
      nb += int'(busy_a);
      if (ifa.sample_valid && ns < 3) begin
        s[ns] = int'(ifa.sample);
        p[ns] = k;
        ns++;
      end
    end
    chk("t3_nsamples", 32'(ns), 3);
    chk("t3_s0", 32'(s[0]), 3);
    chk("t3_s1", 32'(s[1]), 2);
    chk("t3_s2", 32'(s[2]), 3);
    chk("t3_p0", 32'(p[0]), 4);
    chk("t3_p1", 32'(p[1]), 9);
    chk("t3_p2", 32'(p[2]), 14);
    chk("t3_busy_gapless", 32'(nb), 17);
    continuous = 0; stop = 1;
    tick();
    stop = 0;
    chk("t3_stop_busy", 32'(busy_a), 0);
    chk("t3_stop_valid", 32'(ifa.sample_valid), 0);

    // continuous L=4 with back-pressure
    ready = 0; wl = 4; continuous = 1;
    event_in = 1; start_a = 1;
    tick();
    start_a = 0;
    for (int k = 1; k <= 14; k++) begin
      event_in   = (k <= 7);
      continuous = (k <= 9);
      ready      = (k >= 11);
      if (k == 6) begin
        chk("t4_v1", 32'(ifa.sample_valid), 1);
        chk("t4_s1", 32'(ifa.sample), 4);
        chk("t4_o1", 32'(ovr_a), 0);
      end
      if (k == 10) begin
        chk("t4_v2", 32'(ifa.sample_valid), 1);
        chk("t4_s2", 32'(ifa.sample), 2);
        chk("t4_o2", 32'(ovr_a), 1);
      end
      if (k == 12)
        chk("t4_xfer", 32'(ifa.sample_valid), 0);
      if (k == 14) begin
        chk("t4_v3", 32'(ifa.sample_valid), 1);
        chk("t4_s3", 32'(ifa.sample), 0);
        chk("t4_o3_sticky", 32'(ovr_a), 1);
        chk("t4_busy3", 32'(busy_a), 0);
      end
      tick();
    end
    ready = 0; continuous = 0; event_in = 1;
    start_a = 1;
    tick();
    start_a = 0;
    chk("t4_start_clr", 32'(ovr_a), 0);
    repeat (5) tick();
    chk("t4_pend_valid", 32'(ifa.sample_valid), 1);
    chk("t4_pend_sample", 32'(ifa.sample), 4);

    // stop in ARM keeps the pending sample
    start_a = 1;
    tick();
    start_a = 0; stop = 1;
    tick();
    stop = 0;
    chk("t5a_busy", 32'(busy_a), 0);
    repeat (6) tick();
    chk("t5a_valid", 32'(ifa.sample_valid), 1);
    chk("t5a_sample", 32'(ifa.sample), 4);

    // stop on the last COUNT cycle
    event_in = 0; start_a = 1;
    tick();
    start_a = 0;
    repeat (4) tick();
    stop = 1;
    tick();
    stop = 0;
    chk("t5b_busy", 32'(busy_a), 0);
    chk("t5b_valid", 32'(ifa.sample_valid), 1);
    chk("t5b_sample", 32'(ifa.sample), 4);
    repeat (3) tick();
    chk("t5b_hold", 32'(ifa.sample), 4);
    ready = 1;
    tick();
    chk("t5_drain", 32'(ifa.sample_valid), 0);

    // async reset mid-COUNT with a pending sample
    ready = 0; wl = 2; event_in = 1; start_a = 1;
    tick();
    start_a = 0;
    repeat (3) tick();
    chk("t6_pre_sample", 32'(ifa.sample), 2);
    wl = 8; start_a = 1;
    tick();
    start_a = 0;
    repeat (4) tick();
    chk("t6_busy_pre", 32'(busy_a), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_sample", 32'(ifa.sample), 0);
    chk("t6_valid", 32'(ifa.sample_valid), 0);
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_ovr", 32'(ovr_a), 0);
    chk("t6_sat", 32'(ifa.sample_sat), 0);
    #2 reset = 1'b1;
    tick();
    ready = 1; event_in = 1;
    nb = 0; nv = 0;
    repeat (5) begin
      tick();
      nb += int'(busy_a);
      nv += int'(ifa.sample_valid);
    end
    chk("t6_idle_busy", 32'(nb), 0);
    chk("t6_idle_valid", 32'(nv), 0);
    wl = 2; start_a = 1;
    tick();
    start_a = 0;
    tick();
    event_in = 0;
    tick(); tick();
    chk("t6_post_valid", 32'(ifa.sample_valid), 1);
    chk("t6_post_sample", 32'(ifa.sample), 0);

    // window_len=0 with W_BITS=4 -> 16 cycles
    ready = 1; wl = 0; event_in = 1; start_c = 1;
    tick();
    start_c = 0;
    c = 1;
    while (!ifc.sample_valid && c < 60) begin
      tick(); c++;
    end
    chk("t7_time", 32'(c), 18);
    chk("t7_sample", 32'(ifc.sample), 16);
    chk("t7_sat", 32'(ifc.sample_sat), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
